dcache_ctrl: RTL

- Write-back, write-allocate controller that sequences the direct-mapped data-cache storage array for the CPU memory stage.
- Decides hit or miss, writes back dirty victim lines, and refills lines word-by-word from main memory.
- Stalls the pipeline while a miss is being serviced.
- Sits between the CPU MEM stage, the cache array (store/edit/invalid interface) and the memory bus.

---
 rtl/dcache_ctrl_pkg.sv | 28 ++
 rtl/dcache_line_seq.sv | 53 +++++
 rtl/dcache_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/dcache_ctrl_pkg.sv
// Shared cache definitions (the mips_define set): address-split widths and
// controller state encodings used by dcache_ctrl and dcache_line_seq.
package dcache_ctrl_pkg;

    localparam int ADDR_BITS        = 32;
    localparam int WORD_BITS        = 32;
    localparam int WORD_BYTES_WIDTH = 2;
    localparam int LINE_WORDS_WIDTH = 2;
    localparam int LINE_NUM_WIDTH   = 6;
    localparam int TAG_BITS         = ADDR_BITS - LINE_NUM_WIDTH - LINE_WORDS_WIDTH - WORD_BYTES_WIDTH;
    localparam int STAT_BITS        = 32;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BACK = 2'd1;
    localparam logic [1:0] S_FILL = 2'd2;
    localparam logic [1:0] S_WAIT = 2'd3;

    typedef logic [TAG_BITS-1:0]         tag_t;
    typedef logic [LINE_NUM_WIDTH-1:0]   index_t;
    typedef logic [LINE_WORDS_WIDTH-1:0] wcnt_t;

    // Word-aligned byte address of one word inside a cache line.
    function automatic logic [ADDR_BITS-1:0] line_word_addr(input tag_t tag, input index_t index,
                                                            input wcnt_t word);
        return {tag, index, word, {WORD_BYTES_WIDTH{1'b0}}};
    endfunction

endpackage

// File: rtl/dcache_line_seq.sv
// Line sequencer for dcache_ctrl: word counter, latched victim tag/index and
// last-word detect for write-back and refill bursts.
module dcache_line_seq
    import dcache_ctrl_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   start,
    input  logic   advance,
    input  tag_t   victim_tag_in,
    input  index_t victim_index_in,
    output wcnt_t  wcnt,
    output tag_t   victim_tag,
    output index_t victim_index,
    output logic   last_word
);

    wcnt_t  wcnt_q, wcnt_d;
    tag_t   victim_tag_q, victim_tag_d;
    index_t victim_index_q, victim_index_d;

    // The victim is captured on miss entry because the array status changes once refill starts.
    always_comb begin
        wcnt_d         = wcnt_q;
        victim_tag_d   = victim_tag_q;
        victim_index_d = victim_index_q;
        if (start) begin
            wcnt_d         = '0;
            victim_tag_d   = victim_tag_in;
            victim_index_d = victim_index_in;
        end else if (advance) begin
            wcnt_d = wcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt_q         <= '0;
            victim_tag_q   <= '0;
            victim_index_q <= '0;
        end else begin
            wcnt_q         <= wcnt_d;
            victim_tag_q   <= victim_tag_d;
            victim_index_q <= victim_index_d;
        end
    end

    assign wcnt         = wcnt_q;
    assign victim_tag   = victim_tag_q;
    assign victim_index = victim_index_q;
    assign last_word    = (wcnt_q == '1);

endmodule

// File: rtl/dcache_ctrl.sv
// Write-back, write-allocate controller for the direct-mapped data cache.
// Optional hit/miss statistics counters are enabled with macro DCACHE_STAT_EN.
module dcache_ctrl
    import dcache_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [ADDR_BITS-1:0] cpu_addr,
    input  logic [WORD_BITS-1:0] cpu_din,
    output logic [WORD_BITS-1:0] cpu_dout,
    output logic                 cpu_stall,
    output logic [ADDR_BITS-1:0] cache_addr,
    output logic                 cache_store,
    output logic                 cache_edit,
    output logic                 cache_invalid,
    output logic [WORD_BITS-1:0] cache_din,
    input  logic                 cache_hit,
    input  logic                 cache_valid,
    input  logic                 cache_dirty,
    input  logic [TAG_BITS-1:0]  cache_tag,
    input  logic [WORD_BITS-1:0] cache_dout,
    output logic                 mem_cs,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [WORD_BITS-1:0] mem_dout,
    input  logic [WORD_BITS-1:0] mem_din,
    input  logic                 mem_ack,
    output logic [STAT_BITS-1:0] stat_hit,
    output logic [STAT_BITS-1:0] stat_miss
);

    logic [1:0] state_q, state_d;
    logic       seq_start, seq_advance, last_word;
    wcnt_t      wcnt;
    tag_t       victim_tag, cpu_tag;
    index_t     victim_index, cpu_index;

    assign cpu_tag   = cpu_addr[ADDR_BITS-1 -: TAG_BITS];
    assign cpu_index = cpu_addr[WORD_BYTES_WIDTH+LINE_WORDS_WIDTH +: LINE_NUM_WIDTH];

    dcache_line_seq u_line_seq (
        .clk             (clk),
        .rst             (rst),
        .start           (seq_start),
        .advance         (seq_advance),
        .victim_tag_in   (cache_tag),
        .victim_index_in (cpu_index),
        .wcnt            (wcnt),
        .victim_tag      (victim_tag),
        .victim_index    (victim_index),
        .last_word       (last_word)
    );

    always_comb begin
        state_d     = state_q;
        seq_start   = 1'b0;
        seq_advance = 1'b0;
        cpu_stall   = 1'b1;
        cache_addr  = cpu_addr;
        cache_store = 1'b0;
        cache_edit  = 1'b0;
        cache_din   = cpu_din;
        mem_cs      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        case (state_q)
            S_IDLE: begin
                cpu_stall = cpu_req & ~cache_hit;
                if (cpu_req) begin
                    if (cache_hit) begin
                        cache_edit = cpu_we;
                    end else begin
                        seq_start = 1'b1;
                        state_d   = (cache_valid & cache_dirty) ? S_BACK : S_FILL;
                    end
                end
            end
            // Victim words are read from the array by index only, so the tag field is left zero.
            S_BACK: begin
                cache_addr = line_word_addr('0, victim_index, wcnt);
                mem_cs     = 1'b1;
                mem_we     = 1'b1;
                mem_addr   = line_word_addr(victim_tag, victim_index, wcnt);
                if (mem_ack) begin
                    seq_advance = 1'b1;
                    if (last_word) state_d = S_FILL;
                end
            end
            S_FILL: begin
                cache_addr = line_word_addr(cpu_tag, cpu_index, wcnt);
                mem_cs     = 1'b1;
                mem_addr   = line_word_addr(cpu_tag, cpu_index, wcnt);
                if (mem_ack) begin
                    cache_store = 1'b1;
                    cache_din   = mem_din;
                    seq_advance = 1'b1;
                    if (last_word) state_d = S_WAIT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    assign cpu_dout      = cache_dout;
    assign mem_dout      = cache_dout;
    assign cache_invalid = 1'b0;

`ifdef DCACHE_STAT_EN
    logic [STAT_BITS-1:0] stat_hit_q, stat_hit_d, stat_miss_q, stat_miss_d;

    // Counters saturate instead of wrapping so long runs never report a small count.
    always_comb begin
        stat_hit_d  = stat_hit_q;
        stat_miss_d = stat_miss_q;
        if (state_q == S_IDLE && cpu_req) begin
            if (cache_hit && stat_hit_q != '1)   stat_hit_d  = stat_hit_q + 32'd1;
            if (!cache_hit && stat_miss_q != '1) stat_miss_d = stat_miss_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_hit_q  <= '0;
            stat_miss_q <= '0;
        end else begin
            stat_hit_q  <= stat_hit_d;
            stat_miss_q <= stat_miss_d;
        end
    end

    assign stat_hit  = stat_hit_q;
    assign stat_miss = stat_miss_q;
`else
    assign stat_hit  = '0;
    assign stat_miss = '0;
`endif

endmodule
